// File: rtl/audio_in_reader.sv
// audio_in_reader: pops L/R pairs from the ADC-side FIFO, averages them to mono for a valid/ready
// port and tracks per-block peak magnitude. Optional feature macro: AUDIO_IN_DROP_EN.
module audio_in_reader #(
    parameter int SAMPLE_W   = 32,
    parameter int BLOCK_LOG2 = 10
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                audio_in_available,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [SAMPLE_W-1:0] peak_level,
    output logic                block_done,
    output logic                overrun
);

    // Handshake: a sample moves downstream on a rising edge where sample_valid && sample_ready;
    // sample_out holds steady while sample_valid is high, and sample_ready is ignored while it is low.
    typedef enum logic [2:0] {
        S_WAIT,
        S_POP,
        S_HOLD,
        S_DPOP,
        S_DGAP
    } state_t;

    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};

    state_t                state;
    state_t                next_state;
    logic                  read_q;
    logic                  transfer;
    logic                  capture;
    logic [SAMPLE_W:0]     sum;
    logic [SAMPLE_W-1:0]   mono;
    logic [SAMPLE_W-1:0]   mag;
    logic [SAMPLE_W-1:0]   running;
    logic [SAMPLE_W-1:0]   peak_max;
    logic [BLOCK_LOG2-1:0] blk_cnt;

    // One extra sign bit makes the sum exact; dropping bit 0 is the arithmetic halving.
    assign sum      = {left_channel_audio_in[SAMPLE_W-1], left_channel_audio_in}
                    + {right_channel_audio_in[SAMPLE_W-1], right_channel_audio_in};
    assign mono     = sum[SAMPLE_W:1];
    assign transfer = sample_valid && sample_ready;
    assign capture  = (state == S_POP) || (state == S_DPOP);
    assign peak_max = (mag > running) ? mag : running;

    always_comb begin
        mag = mono;
        if (mono == MOST_NEG) begin
            mag = ~MOST_NEG;
        end else if (mono[SAMPLE_W-1]) begin
            mag = -mono;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_WAIT: if (audio_in_available) next_state = S_POP;
            S_POP:  next_state = S_HOLD;
            S_HOLD: begin
                if (transfer) begin
                    next_state = S_WAIT;
                end
`ifdef AUDIO_IN_DROP_EN
                else if (audio_in_available) begin
                    next_state = S_DPOP;
                end
`endif
            end
            S_DPOP: next_state = S_DGAP;
            S_DGAP: next_state = (transfer || !sample_valid) ? S_WAIT : S_HOLD;
            default: next_state = S_WAIT;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= S_WAIT;
            read_q       <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            peak_level   <= '0;
            block_done   <= 1'b0;
            running      <= '0;
            blk_cnt      <= '0;
        end else begin
            state      <= next_state;
            read_q     <= (next_state == S_POP) || (next_state == S_DPOP);
            block_done <= 1'b0;
            if (state == S_POP) begin
                sample_out   <= mono;
                sample_valid <= 1'b1;
            end else if (transfer) begin
                sample_valid <= 1'b0;
            end
            // The sample that wraps the counter still belongs to the block being closed.
            if (capture) begin
                blk_cnt <= blk_cnt + 1'b1;
                if (&blk_cnt) begin
                    peak_level <= peak_max;
                    running    <= '0;
                    block_done <= 1'b1;
                end else begin
                    running <= peak_max;
                end
            end
        end
    end

    // Gate the strobe so the FIFO is never popped while reset is being applied.
    assign read_audio_in = read_q && !reset;

`ifdef AUDIO_IN_DROP_EN
    logic overrun_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (state == S_DPOP) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_audio_in_reader.sv
// tb_audio_in_reader: FIFO model feeding audio_in_reader; vector table, hand-written corner sequences
// and randomized traffic checked against a mono/peak reference model. Follows AUDIO_IN_DROP_EN.
`timescale 1ns/1ps
module tb_audio_in_reader;

    localparam int W     = 32;
    localparam int BL    = 2;
    localparam int BLOCK = 1 << BL;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [W-1:0] mono;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         available;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         read;
    logic [W-1:0] sample_out;
    logic         valid;
    logic         ready;
    logic [W-1:0] peak_level;
    logic         block_done;
    logic         overrun;

    audio_in_reader #(.SAMPLE_W(W), .BLOCK_LOG2(BL)) dut (
        .CLOCK_50              (clk),
        .reset                 (reset),
        .audio_in_available    (available),
        .left_channel_audio_in (left),
        .right_channel_audio_in(right),
        .read_audio_in         (read),
        .sample_out            (sample_out),
        .sample_valid          (valid),
        .sample_ready          (ready),
        .peak_level            (peak_level),
        .block_done            (block_done),
        .overrun               (overrun)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected to finish earlier");
        $fatal(1);
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_cond(string name, bit ok, string detail);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_mono(logic [W-1:0] l, logic [W-1:0] r);
        longint a;
        longint b;
        longint s;
        a = $signed(l);
        b = $signed(r);
        s = (a + b) >>> 1;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_mag(logic [W-1:0] m);
        longint v;
        v = $signed(m);
        if (v < 0) v = -v;
        if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
        return v[W-1:0];
    endfunction

    logic [W-1:0] fifo_l[$];
    logic [W-1:0] fifo_r[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] peak_q[$];
    logic [W-1:0] blk_run = '0;
    int           blk_n = 0;
    bit           held = 0;
    bit           exp_overrun = 0;
    bit           pop_pending = 0;
    int           cyc = 0;
    int           last_read = -100;
    int           read_count = 0;
    int           xfer_count = 0;
    int           bd_count = 0;

    task automatic refresh();
        available = (fifo_l.size() != 0);
        left      = (fifo_l.size() != 0) ? fifo_l[0] : '0;
        right     = (fifo_r.size() != 0) ? fifo_r[0] : '0;
    endtask

    task automatic push(logic [W-1:0] l, logic [W-1:0] r);
        fifo_l.push_back(l);
        fifo_r.push_back(r);
        refresh();
    endtask

    // The Audio_Controller FIFO advances just after the edge that saw the strobe.
    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            void'(fifo_l.pop_front());
            void'(fifo_r.pop_front());
            pop_pending = 0;
            refresh();
        end
    end

    // Scoreboard: outputs sampled on the falling edge describe what the next rising edge does.
    always @(negedge clk) begin
        logic [W-1:0] m;
        logic [W-1:0] mg;
        cyc++;
        if (reset) begin
            exp_q.delete();
            peak_q.delete();
            held        = 0;
            blk_n       = 0;
            blk_run     = '0;
            exp_overrun = 0;
        end else begin
            if (block_done) begin
                bd_count++;
                if (peak_q.size() == 0)
                    check_cond("block_done", 0, "got pulse, expected none");
                else
                    check("peak_level", peak_level, peak_q.pop_front());
            end
            if (read) begin
                read_count++;
                check_cond("read_spacing", (cyc - last_read) >= 3,
                           $sformatf("got gap %0d cycles, expected >= 3", cyc - last_read));
                last_read = cyc;
                if (fifo_l.size() == 0) begin
                    check_cond("pop_empty", 0, "got read with FIFO empty, expected none");
                end else begin
                    m  = ref_mono(fifo_l[0], fifo_r[0]);
                    mg = ref_mag(m);
                    if (mg > blk_run) blk_run = mg;
                    blk_n++;
                    if (blk_n == BLOCK) begin
                        peak_q.push_back(blk_run);
                        blk_n   = 0;
                        blk_run = '0;
                    end
                    if (held) begin
`ifdef AUDIO_IN_DROP_EN
                        exp_overrun = 1;
`else
                        check_cond("pop_while_holding", 0, "got read while sample pending, expected none");
`endif
                    end else begin
                        exp_q.push_back(m);
                        held = 1;
                    end
                    pop_pending = 1;
                end
            end
            if (valid && ready) begin
                xfer_count++;
                if (exp_q.size() == 0)
                    check_cond("transfer", 0, $sformatf("got transfer of %h, expected none", sample_out));
                else
                    check("sample_out", sample_out, exp_q.pop_front());
                held = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        @(negedge clk);
        while (!valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_cond(name, valid === 1'b1, "got sample_valid low for 50 cycles, expected high");
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(fifo_l.size() == 0 && !valid && !read) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_cond("idle", n < 1000, "got busy after 1000 cycles, expected idle");
    endtask

    task automatic reset_pulse();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl[12];
    logic [W-1:0] edge_vals[4];

    initial begin
        int bd0;
        int rd0;
        int xc;
        bit stable;

        tbl[0]  = '{32'h0000_0010, 32'h0000_0030, 32'h0000_0020};
        tbl[1]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        tbl[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        tbl[3]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        tbl[4]  = '{32'h0000_0004, 32'h0000_0006, 32'h0000_0005};
        tbl[5]  = '{32'hFFFF_FFF6, 32'hFFFF_FFF8, 32'hFFFF_FFF7};
        tbl[6]  = '{32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0003};
        tbl[7]  = '{32'h0000_0000, 32'h0000_0003, 32'h0000_0001};
        tbl[8]  = '{32'hFFFF_FFFD, 32'h0000_0000, 32'hFFFF_FFFE};
        tbl[9]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[11] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0002};
        edge_vals[0] = 32'h8000_0000;
        edge_vals[1] = 32'h7FFF_FFFF;
        edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h0000_0000;

        // T1: reset held with a pair waiting
        reset = 1'b1;
        ready = 1'b1;
        refresh();
        push(32'h1234_5678, 32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_read", read, 0);
            check("t1_valid", valid, 0);
            check("t1_peak", peak_level, 0);
            check("t1_block_done", block_done, 0);
            check("t1_overrun", overrun, 0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t1_read_after_reset", read, 0);
        wait_idle();

        // T2: exact latency of one pair
        tick();
        push(32'h0000_0010, 32'h0000_0030);
        @(negedge clk);
        check("t2_read_n", read, 0);
        @(negedge clk);
        check("t2_read_n1", read, 1);
        check("t2_valid_n1", valid, 0);
        @(negedge clk);
        check("t2_read_n2", read, 0);
        check("t2_valid_n2", valid, 1);
        check("t2_sample_n2", sample_out, 32'h0000_0020);
        @(negedge clk);
        check("t2_valid_n3", valid, 0);
        wait_idle();

        // T3/T4: vector table, block-aligned by a reset
        reset_pulse();
        bd0 = bd_count;
        for (int i = 0; i < 12; i++) begin
            tick();
            push(tbl[i].l, tbl[i].r);
            wait_valid($sformatf("tbl_valid_%0d", i));
            check($sformatf("tbl_mono_%0d", i), sample_out, tbl[i].mono);
        end
        wait_idle();
        check("tbl_block_count", bd_count - bd0, 3);
        check("t4_peak_final", peak_level, 32'h0000_0002);

        // T5: long stall with the FIFO non-empty
        reset_pulse();
        ready = 1'b0;
        tick();
        push(32'h0000_0100, 32'h0000_0300);
        wait_valid("t5_valid");
        tick();
        for (int i = 0; i < 20; i++) push($urandom, $urandom);
        rd0    = read_count;
        stable = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sample_out !== 32'h0000_0200 || valid !== 1'b1) stable = 0;
        end
        check_cond("t5_stable", stable, "got sample_out/valid changing during stall, expected 200/1");
`ifdef AUDIO_IN_DROP_EN
        check_cond("t5_drop_pops", (read_count - rd0) >= 15,
                   $sformatf("got %0d pops in 50 cycles, expected >= 15", read_count - rd0));
        check("t5_overrun", overrun, 1);
`else
        check("t5_no_pops", read_count - rd0, 0);
        check("t5_overrun", overrun, 0);
`endif
        tick();
        ready = 1'b1;
        xc = xfer_count;
        tick();
        ready = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_one_transfer", xfer_count - xc, 1);
        tick();
        ready = 1'b1;
        wait_idle();

        // T6: reset while a sample is held
        reset_pulse();
        ready = 1'b0;
        tick();
        push(32'h0000_AAA0, 32'h0000_0000);
        wait_valid("t6_valid");
        repeat (3) @(negedge clk);
        xc = xfer_count;
        tick();
        reset = 1'b1;
        push(32'h0000_2000, 32'h0000_2000);
        @(negedge clk);
        check("t6_read_reset_cycle", read, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("t6_valid_after_reset", valid, 0);
        check("t6_read_after_reset", read, 0);
        tick();
        ready = 1'b1;
        wait_idle();
        check("t6_transfers", xfer_count - xc, 1);

        // Randomized traffic with random backpressure
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            tick();
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && fifo_l.size() < 6) begin
                if ($urandom_range(0, 7) == 0)
                    push(edge_vals[$urandom_range(0, 3)], edge_vals[$urandom_range(0, 3)]);
                else
                    push($urandom, $urandom);
            end
        end
        tick();
        ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        check("final_exp_q_empty", exp_q.size(), 0);
        check("final_peak_q_empty", peak_q.size(), 0);
        check("final_overrun", overrun, exp_overrun);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
